// File: rtl/data_mem_responder.sv
// data_mem_responder
//
// Data-memory responder for a single-cycle controller. Each MemRead/MemWrite
// request is served as a multi-cycle access. busy is held while the access is
// in progress so the controller stalls. Accesses run IDLE -> WAIT -> DONE.
//
// Optional feature: define DMEM_RDBUF_EN to add a single-entry read buffer.
// A read in IDLE that hits the buffer completes at once, with no busy cycles.
//
// Ports:
//   clock      in   rising-edge clock
//   reset      in   synchronous, active-high reset
//   MemRead    in   read request (level, held while busy)
//   MemWrite   in   write request (level, held while busy); wins over MemRead
//   Address    in   byte address; word index = Address[$clog2(NWORDS)+1:2]
//   WriteData  in   store data (held while busy)
//   ReadData   out  load data; registered, with combinational bypass in DONE/hit
//   busy       out  access in progress, controller must stall

module data_mem_responder #(
  parameter int unsigned NBITS   = 8,
  parameter int unsigned NWORDS  = 32,
  parameter int unsigned LATENCY = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             MemRead,
  input  logic             MemWrite,
  input  logic [NBITS-1:0] Address,
  input  logic [NBITS-1:0] WriteData,
  output logic [NBITS-1:0] ReadData,
  output logic             busy
);

  localparam int unsigned IW = $clog2(NWORDS);
  localparam int unsigned CW = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             wr_q, wr_d;      // latched: access is a write
  logic             both_q, both_d;  // latched: read and write both requested
  logic [NBITS-1:0] rd_q, rd_d;
  logic             mem_we;

  logic [NBITS-1:0] mem [NWORDS];

  logic [IW-1:0] index;
  logic          req;
  logic          hit;
  logic          unused_addr;

  assign index       = Address[IW+1:2];
  assign req         = MemRead | MemWrite;
  // Byte-offset and upper address bits carry no meaning here.
  assign unused_addr = ^Address;

`ifdef DMEM_RDBUF_EN
  logic             buf_valid_q, buf_valid_d;
  logic [IW-1:0]    buf_tag_q, buf_tag_d;
  logic [NBITS-1:0] buf_data_q, buf_data_d;

  assign hit = MemRead & ~MemWrite & buf_valid_q & (buf_tag_q == index);
`else
  assign hit = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    wr_d     = wr_q;
    both_d   = both_q;
    rd_d     = rd_q;
    mem_we   = 1'b0;
    busy     = 1'b0;
    ReadData = rd_q;
`ifdef DMEM_RDBUF_EN
    buf_valid_d = buf_valid_q;
    buf_tag_d   = buf_tag_q;
    buf_data_d  = buf_data_q;
`endif

    case (state_q)
      StIdle: begin
        if (hit) begin
`ifdef DMEM_RDBUF_EN
          ReadData = buf_data_q;
          rd_d     = buf_data_q;
`endif
        end else if (req) begin
          busy    = 1'b1;
          idx_d   = index;
          wr_d    = MemWrite;
          both_d  = MemWrite & MemRead;
          cnt_d   = CW'(LATENCY - 1);
          state_d = (LATENCY == 1) ? StDone : StWait;
        end
      end
      StWait: begin
        busy = 1'b1;
        if (!req) begin
          // Controller withdrew the request: abandon the access.
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
        if (wr_q) begin
          mem_we = 1'b1;
          if (both_q) begin
            ReadData = WriteData;
            rd_d     = WriteData;
          end
`ifdef DMEM_RDBUF_EN
          if (buf_valid_q && buf_tag_q == idx_q) buf_data_d = WriteData;
`endif
        end else begin
          ReadData = mem[idx_q];
          rd_d     = mem[idx_q];
`ifdef DMEM_RDBUF_EN
          buf_valid_d = 1'b1;
          buf_tag_d   = idx_q;
          buf_data_d  = mem[idx_q];
`endif
        end
      end
      default: state_d = StIdle;
    endcase

    // Reset drops any in-flight write and reports no activity.
    if (reset) begin
      busy   = 1'b0;
      mem_we = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      wr_q    <= 1'b0;
      both_q  <= 1'b0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wr_q    <= wr_d;
      both_q  <= both_d;
      rd_q    <= rd_d;
    end
  end

`ifdef DMEM_RDBUF_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      buf_valid_q <= 1'b0;
      buf_tag_q   <= '0;
      buf_data_q  <= '0;
    end else begin
      buf_valid_q <= buf_valid_d;
      buf_tag_q   <= buf_tag_d;
      buf_data_q  <= buf_data_d;
    end
  end
`endif

  // RAM has no reset; contents are undefined until written.
  always_ff @(posedge clock) begin
    if (mem_we) mem[idx_q] <= WriteData;
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder. Three instances run with
// LATENCY = 3, 1 and 5; each has its own request signals and one shared reset.
// A behavioural memory/buffer model predicts busy-cycle counts and ReadData.

module tb_data_mem_responder;

  typedef struct packed {
    logic       r;
    logic       w;
    logic [7:0] a;
    logic [7:0] d;
  } op_t;

  logic       clock;
  logic       reset;
  logic       mr   [3];
  logic       mw   [3];
  logic [7:0] addr [3];
  logic [7:0] wdat [3];
  logic [7:0] rd   [3];
  logic       bz   [3];

  int n_err = 0;
  int n_chk = 0;

  // Reference model state, one copy per instance.
  logic [7:0] m_mem [3][32];
  logic [7:0] m_rd  [3];
  bit         m_bv  [3];
  int         m_bt  [3];
  logic [7:0] m_bd  [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned Lat = (g == 0) ? 3 : ((g == 1) ? 1 : 5);
    data_mem_responder #(
      .NBITS  (8),
      .NWORDS (32),
      .LATENCY(Lat)
    ) u_dut (
      .clock    (clock),
      .reset    (reset),
      .MemRead  (mr[g]),
      .MemWrite (mw[g]),
      .Address  (addr[g]),
      .WriteData(wdat[g]),
      .ReadData (rd[g]),
      .busy     (bz[g])
    );
  end

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  function automatic int lat_of(input int d);
    return (d == 0) ? 3 : ((d == 1) ? 1 : 5);
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      m_rd[d] = 8'h00;
      m_bv[d] = 1'b0;
    end
  endtask

  // Predict busy-cycle count and ReadData at completion, then update state.
  task automatic model_access(input int d, input bit r, input bit w, input logic [7:0] a,
                              input logic [7:0] wd, output int eb, output logic [7:0] er);
    int  idx;
    bit  use_buf;
    idx     = (int'(a) / 4) % 32;
    use_buf = 1'b0;
`ifdef DMEM_RDBUF_EN
    use_buf = r && !w && m_bv[d] && (m_bt[d] == idx);
`endif
    if (use_buf) begin
      eb      = 0;
      er      = m_bd[d];
      m_rd[d] = er;
    end else if (w) begin
      eb           = lat_of(d);
      m_mem[d][idx] = wd;
      if (r) m_rd[d] = wd;
      er = m_rd[d];
      if (m_bv[d] && m_bt[d] == idx) m_bd[d] = wd;
    end else begin
      eb      = lat_of(d);
      er      = m_mem[d][idx];
      m_rd[d] = er;
      m_bv[d] = 1'b1;
      m_bt[d] = idx;
      m_bd[d] = er;
    end
  endtask

  // Called just after a rising edge. Holds the request until busy drops,
  // reports busy cycles and ReadData in the completion cycle.
  task automatic run_access(input int d, input bit r, input bit w, input logic [7:0] a,
                            input logic [7:0] wd, output int bc, output logic [7:0] rdv,
                            output bit to);
    bc  = 0;
    rdv = 8'h00;
    to  = 1'b1;
    mr[d]   = r;
    mw[d]   = w;
    addr[d] = a;
    wdat[d] = wd;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      if (bz[d]) begin
        bc++;
      end else begin
        rdv = rd[d];
        to  = 1'b0;
        break;
      end
      @(posedge clock); #1;
    end
    @(posedge clock); #1;
    mr[d] = 1'b0;
    mw[d] = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    for (int d = 0; d < 3; d++) begin
      n_chk++;
      if (bz[d] !== 1'b0) begin
        n_err++; $display("FAIL reset_busy[%0d] got=%b exp=0", d, bz[d]);
      end
      n_chk++;
      if (rd[d] !== 8'h00) begin
        n_err++; $display("FAIL reset_rdata[%0d] got=%h exp=00", d, rd[d]);
      end
    end
    @(posedge clock); #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_write_read();
    op_t        ops [4] = '{'{1'b0, 1'b1, 8'h08, 8'h5A}, '{1'b1, 1'b0, 8'h08, 8'h00},
                            '{1'b1, 1'b0, 8'h0B, 8'h00}, '{1'b0, 1'b1, 8'h14, 8'h21}};
    int         eb, bc;
    logic [7:0] er, rdv;
    bit         to;
    foreach (ops[i]) begin
      model_access(0, ops[i].r, ops[i].w, ops[i].a, ops[i].d, eb, er);
      run_access(0, ops[i].r, ops[i].w, ops[i].a, ops[i].d, bc, rdv, to);
      n_chk++;
      if (to || bc != eb) begin
        n_err++; $display("FAIL wr_rd[%0d] busy_cycles got=%0d exp=%0d", i, bc, eb);
      end
      n_chk++;
      if (rdv !== er) begin
        n_err++; $display("FAIL wr_rd[%0d] read_data got=%h exp=%h", i, rdv, er);
      end
    end
  endtask

  task automatic test_read_write_both();
    op_t        ops [2] = '{'{1'b1, 1'b1, 8'h10, 8'h33}, '{1'b1, 1'b0, 8'h10, 8'h00}};
    int         eb, bc;
    logic [7:0] er, rdv;
    bit         to;
    foreach (ops[i]) begin
      model_access(0, ops[i].r, ops[i].w, ops[i].a, ops[i].d, eb, er);
      run_access(0, ops[i].r, ops[i].w, ops[i].a, ops[i].d, bc, rdv, to);
      n_chk++;
      if (to || bc != eb) begin
        n_err++; $display("FAIL both[%0d] busy_cycles got=%0d exp=%0d", i, bc, eb);
      end
      n_chk++;
      if (rdv !== er) begin
        n_err++; $display("FAIL both[%0d] read_data got=%h exp=%h", i, rdv, er);
      end
    end
  endtask

  task automatic test_abort();
    int         eb, bc;
    logic [7:0] er, rdv;
    bit         to;
    // Withdrawal in cycle 1.
    mw[0] = 1'b1; addr[0] = 8'h14; wdat[0] = 8'h77;
    @(negedge clock);
    n_chk++;
    if (bz[0] !== 1'b1) begin n_err++; $display("FAIL abort_c0_busy got=%b exp=1", bz[0]); end
    @(posedge clock); #1;
    mw[0] = 1'b0;
    @(negedge clock);
    n_chk++;
    if (bz[0] !== 1'b1) begin n_err++; $display("FAIL abort_c1_busy got=%b exp=1", bz[0]); end
    @(posedge clock); #1;
    @(negedge clock);
    n_chk++;
    if (bz[0] !== 1'b0) begin n_err++; $display("FAIL abort_c2_busy got=%b exp=0", bz[0]); end
    n_chk++;
    if (rd[0] !== m_rd[0]) begin
      n_err++; $display("FAIL abort_c2_rdata got=%h exp=%h", rd[0], m_rd[0]);
    end
    @(posedge clock); #1;
    model_access(0, 1'b1, 1'b0, 8'h14, 8'h00, eb, er);
    run_access(0, 1'b1, 1'b0, 8'h14, 8'h00, bc, rdv, to);
    n_chk++;
    if (to || rdv !== er) begin
      n_err++; $display("FAIL abort_readback got=%h exp=%h", rdv, er);
    end
    // Reset in cycle 1.
    mw[0] = 1'b1; addr[0] = 8'h14; wdat[0] = 8'h77;
    @(posedge clock); #1;
    mw[0] = 1'b0;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    model_reset();
    @(negedge clock);
    n_chk++;
    if (bz[0] !== 1'b0) begin n_err++; $display("FAIL rstabort_busy got=%b exp=0", bz[0]); end
    n_chk++;
    if (rd[0] !== 8'h00) begin n_err++; $display("FAIL rstabort_rdata got=%h exp=00", rd[0]); end
    @(posedge clock); #1;
    model_access(0, 1'b1, 1'b0, 8'h14, 8'h00, eb, er);
    run_access(0, 1'b1, 1'b0, 8'h14, 8'h00, bc, rdv, to);
    n_chk++;
    if (to || bc != eb || rdv !== er) begin
      n_err++; $display("FAIL rstabort_readback got=%h/%0d exp=%h/%0d", rdv, bc, er, eb);
    end
  endtask

  task automatic test_read_buffer();
    op_t        ops [6] = '{'{1'b1, 1'b0, 8'h08, 8'h00}, '{1'b1, 1'b0, 8'h08, 8'h00},
                            '{1'b0, 1'b1, 8'h08, 8'hC1}, '{1'b1, 1'b0, 8'h08, 8'h00},
                            '{1'b0, 1'b1, 8'h0C, 8'h4E}, '{1'b1, 1'b0, 8'h0C, 8'h00}};
    int         eb, bc;
    logic [7:0] er, rdv;
    bit         to;
    foreach (ops[i]) begin
      model_access(0, ops[i].r, ops[i].w, ops[i].a, ops[i].d, eb, er);
      run_access(0, ops[i].r, ops[i].w, ops[i].a, ops[i].d, bc, rdv, to);
      n_chk++;
      if (to || bc != eb) begin
        n_err++; $display("FAIL rdbuf[%0d] busy_cycles got=%0d exp=%0d", i, bc, eb);
      end
      n_chk++;
      if (rdv !== er) begin
        n_err++; $display("FAIL rdbuf[%0d] read_data got=%h exp=%h", i, rdv, er);
      end
    end
  endtask

  task automatic test_latency_sweep();
    op_t        ops [7] = '{'{1'b0, 1'b1, 8'h08, 8'h96}, '{1'b1, 1'b0, 8'h08, 8'h00},
                            '{1'b0, 1'b1, 8'h7C, 8'hE7}, '{1'b1, 1'b0, 8'h7C, 8'h00},
                            '{1'b0, 1'b1, 8'h80, 8'h3C}, '{1'b1, 1'b0, 8'h00, 8'h00},
                            '{1'b1, 1'b0, 8'h7C, 8'h00}};
    int         eb, bc;
    logic [7:0] er, rdv;
    bit         to;
    for (int d = 1; d < 3; d++) begin
      foreach (ops[i]) begin
        model_access(d, ops[i].r, ops[i].w, ops[i].a, ops[i].d, eb, er);
        run_access(d, ops[i].r, ops[i].w, ops[i].a, ops[i].d, bc, rdv, to);
        n_chk++;
        if (to || bc != eb) begin
          n_err++; $display("FAIL sweep[L%0d][%0d] busy_cycles got=%0d exp=%0d",
                            lat_of(d), i, bc, eb);
        end
        n_chk++;
        if (rdv !== er) begin
          n_err++; $display("FAIL sweep[L%0d][%0d] read_data got=%h exp=%h",
                            lat_of(d), i, rdv, er);
        end
      end
    end
  endtask

  task automatic test_random();
    int         eb, bc, kind;
    logic [7:0] er, rdv, a, wd;
    bit         to, r, w;
    for (int d = 0; d < 3; d++) begin
      // Give every word a defined value first.
      for (int i = 0; i < 32; i++) begin
        wd = 8'($urandom);
        model_access(d, 1'b0, 1'b1, 8'(4 * i), wd, eb, er);
        run_access(d, 1'b0, 1'b1, 8'(4 * i), wd, bc, rdv, to);
        n_chk++;
        if (to || bc != eb) begin
          n_err++; $display("FAIL fill[%0d][%0d] busy_cycles got=%0d exp=%0d", d, i, bc, eb);
        end
      end
      for (int i = 0; i < 60; i++) begin
        kind = $urandom_range(0, 3);
        r    = (kind != 2);
        w    = (kind >= 2);
        if ($urandom_range(0, 1) == 1) a = 8'(4 * $urandom_range(0, 3) + $urandom_range(0, 3));
        else                           a = 8'($urandom_range(0, 255));
        wd = 8'($urandom);
        model_access(d, r, w, a, wd, eb, er);
        run_access(d, r, w, a, wd, bc, rdv, to);
        n_chk++;
        if (to || bc != eb) begin
          n_err++; $display("FAIL rand[%0d][%0d] busy_cycles got=%0d exp=%0d r=%b w=%b a=%h",
                            d, i, bc, eb, r, w, a);
        end
        n_chk++;
        if (rdv !== er) begin
          n_err++; $display("FAIL rand[%0d][%0d] read_data got=%h exp=%h r=%b w=%b a=%h",
                            d, i, rdv, er, r, w, a);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    for (int d = 0; d < 3; d++) begin
      mr[d] = 1'b0; mw[d] = 1'b0; addr[d] = 8'h00; wdat[d] = 8'h00;
      m_rd[d] = 8'h00; m_bv[d] = 1'b0; m_bt[d] = 0; m_bd[d] = 8'h00;
      for (int i = 0; i < 32; i++) m_mem[d][i] = 8'h00;
    end
    #1;
    test_reset();
    test_write_read();
    test_read_write_both();
    test_abort();
    test_read_buffer();
    test_latency_sweep();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
